tile_query_arbiter: RTL and testbench

Shares the single background tile-map lookup port between several requesters: cursor hover check, tower placement, and bloon path follower. Each requester presents a pixel coordinate. The block round-robin arbitrates, converts the winning coordinate to a 32×32 tile index, drives the tile-map address, registers the 1-bit path/terrain result, and returns it with a one-cycle response strobe. It sits between the game-logic requesters and the combinational 20×15 background tile map.

---
 rtl/tile_query_arbiter_if.sv | 28 ++
 rtl/tile_query_arbiter.sv | 94 +++++++++
 tb/tb_tile_query_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_query_arbiter_if.sv
// Requester, response and tile-map signals of the tile query arbiter.
// slave is the arbiter's view; master is the game-logic / tile-map side.
interface tile_query_arbiter_if #(
  parameter int N_REQ   = 3,
  parameter int COORD_W = 10
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*COORD_W-1:0] query_x;
  logic [N_REQ*COORD_W-1:0] query_y;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         rsp_valid;
  logic                     rsp_data;
  logic                     rsp_oob;
  logic                     busy;
  logic [4:0]               tile_x;
  logic [3:0]               tile_y;
  logic                     tile_data_i;

  modport master (
    output req, query_x, query_y, tile_data_i,
    input  grant, rsp_valid, rsp_data, rsp_oob, busy, tile_x, tile_y
  );

  modport slave (
    input  req, query_x, query_y, tile_data_i,
    output grant, rsp_valid, rsp_data, rsp_oob, busy, tile_x, tile_y
  );
endinterface

// File: rtl/tile_query_arbiter.sv
// Round-robin arbiter sharing one combinational tile-map lookup port.
// One query per three cycles: IDLE (sample) -> LOOKUP (address) -> RESP (strobe).
module tile_query_arbiter #(
  parameter int N_REQ      = 3,
  parameter int COORD_W    = 10,
  parameter int TILE_SHIFT = 5,
  parameter int TILES_X    = 20,
  parameter int TILES_Y    = 15
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  tile_query_arbiter_if.slave  bus
);
  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, owner, pick;
  logic               pick_vld;
  logic [COORD_W-1:0] lat_x, lat_y, sel_x, sel_y, cx, cy;
  logic               oob, rsp_data_q, rsp_oob_q;

  // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (bus.req[j]) begin
        pick     = PTR_W'(j);
        pick_vld = 1'b1;
      end
    end
  end

  assign sel_x = bus.query_x[int'(pick)*COORD_W +: COORD_W];
  assign sel_y = bus.query_y[int'(pick)*COORD_W +: COORD_W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      rsp_data_q <= 1'b0;
      rsp_oob_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) begin
        owner <= pick;
        lat_x <= sel_x;
        lat_y <= sel_y;
      end
      if (state == LOOKUP) begin
        rsp_data_q <= oob ? 1'b0 : bus.tile_data_i;
        rsp_oob_q  <= oob;
      end
      if (state == RESP)
        rr_ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
    end
  end

  assign cx  = lat_x >> TILE_SHIFT;
  assign cy  = lat_y >> TILE_SHIFT;
  assign oob = (int'(cx) >= TILES_X) || (int'(cy) >= TILES_Y);

  // Address is parked at 0 outside LOOKUP and for out-of-range queries.
  assign bus.tile_x = (state == LOOKUP && !oob) ? cx[4:0] : 5'd0;
  assign bus.tile_y = (state == LOOKUP && !oob) ? cy[3:0] : 4'd0;

  for (genvar k = 0; k < N_REQ; k++) begin : g_req
    assign bus.grant[k]     = (state != IDLE) && (owner == PTR_W'(k));
    assign bus.rsp_valid[k] = (state == RESP) && (owner == PTR_W'(k));
  end

  assign bus.busy     = (state != IDLE);
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_oob  = rsp_oob_q;
endmodule

// File: tb/tb_tile_query_arbiter.sv
// Bench for tile_query_arbiter: directed test-plan cases plus random traffic
// checked every cycle against a transaction-schedule reference model.
module tb_tile_query_arbiter;
  localparam int N  = 3;
  localparam int CW = 10;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  tile_query_arbiter_if #(.N_REQ(N), .COORD_W(CW)) bus();

  tile_query_arbiter #(
    .N_REQ(N), .COORD_W(CW), .TILE_SHIFT(5), .TILES_X(20), .TILES_Y(15)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  logic [N-1:0]  req_r = '0;
  logic [CW-1:0] qx [N];
  logic [CW-1:0] qy [N];

  assign bus.req = req_r;
  always_comb begin
    bus.query_x = '0;
    bus.query_y = '0;
    for (int k = 0; k < N; k++) begin
      bus.query_x[k*CW +: CW] = qx[k];
      bus.query_y[k*CW +: CW] = qy[k];
    end
  end

  // Background map: top row from column 8, left column from row 7, and a diagonal.
  function automatic bit path_bit(int tx, int ty);
    return (ty == 0 && tx >= 8) || (tx == 0 && ty >= 7) || (tx == ty + 3);
  endfunction

  assign bus.tile_data_i = path_bit(int'(bus.tile_x), int'(bus.tile_y));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a sampled query occupies the next two cycles
  // (address cycle, then response cycle) and blocks sampling for three.
  typedef struct {
    bit vld;
    int s;
    int owner;
    int tx;
    int ty;
    bit oob;
    bit data;
  } txn_t;

  txn_t rec;
  int   cyc = 0;
  int   next_ok = 0;
  int   ptr = 0;

  always @(posedge Clk) begin
    int  win;
    bit  found;
    int  k;
    win   = 0;
    found = 1'b0;
    if (!Reset_n) begin
      rec.vld = 1'b0;
      ptr     = 0;
      next_ok = 0;
    end else if (cyc >= next_ok && |req_r) begin
      for (int i = N - 1; i >= 0; i--) begin
        k = (ptr + i) % N;
        if (req_r[k]) begin
          win   = k;
          found = 1'b1;
        end
      end
      if (found) begin
        rec.vld   = 1'b1;
        rec.s     = cyc;
        rec.owner = win;
        rec.tx    = int'(qx[win]) / 32;
        rec.ty    = int'(qy[win]) / 32;
        rec.oob   = (rec.tx >= 20) || (rec.ty >= 15);
        rec.data  = rec.oob ? 1'b0 : path_bit(rec.tx, rec.ty);
        ptr       = (win + 1) % N;
        next_ok   = cyc + 3;
      end
    end
    cyc++;
  end

  always @(negedge Clk) begin
    logic [N-1:0] eg, erv;
    int etx, ety;
    bit ebusy;
    eg = '0; erv = '0; etx = 0; ety = 0; ebusy = 1'b0;
    if (Reset_n) begin
      if (rec.vld && (cyc == rec.s + 1 || cyc == rec.s + 2)) begin
        eg    = N'(1) << rec.owner;
        ebusy = 1'b1;
      end
      if (rec.vld && cyc == rec.s + 1 && !rec.oob) begin
        etx = rec.tx;
        ety = rec.ty;
      end
      if (rec.vld && cyc == rec.s + 2) begin
        erv = eg;
        chk("mon_rsp_data", 32'(bus.rsp_data), 32'(rec.data));
        chk("mon_rsp_oob", 32'(bus.rsp_oob), 32'(rec.oob));
      end
      chk("mon_grant", 32'(bus.grant), 32'(eg));
      chk("mon_rsp_valid", 32'(bus.rsp_valid), 32'(erv));
      chk("mon_busy", 32'(bus.busy), 32'(ebusy));
      chk("mon_tile_x", 32'(bus.tile_x), 32'(etx));
      chk("mon_tile_y", 32'(bus.tile_y), 32'(ety));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_rsp(int k, output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    for (int n = 0; n < 12 && !got; n++) begin
      tick();
      if (bus.rsp_valid[k]) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_grant(int k);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 12 && !got; n++) begin
      tick();
      if (bus.grant[k]) got = 1'b1;
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic query(int k, int x, int y, output int lat);
    int t0, at;
    tick();
    qx[k] = CW'(x);
    qy[k] = CW'(y);
    req_r[k] = 1'b1;
    t0 = cyc;
    wait_rsp(k, at);
    req_r[k] = 1'b0;
    lat = at - t0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_tile_x"}, 32'(bus.tile_x), 32'd0);
    chk({tag, "_tile_y"}, 32'(bus.tile_y), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_rsp_oob"}, 32'(bus.rsp_oob), 32'd0);
  endtask

  function automatic logic [CW-1:0] rnd_coord(int lim);
    if ($urandom_range(7) == 0) return CW'($urandom_range(1023, lim));
    return CW'($urandom_range(lim - 1, 0));
  endfunction

  initial begin
    int lat, n, owner;
    int ord [9];
    int at  [9];
    rec.vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      qx[k] = '0;
      qy[k] = '0;
    end

    #3;
    chk_all_zero("reset");
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_n = 1'b1;

    query(0, 256, 0, lat);
    chk("single_latency", 32'(lat), 32'd2);
    chk("single_data", 32'(bus.rsp_data), 32'd1);
    chk("single_oob", 32'(bus.rsp_oob), 32'd0);

    query(1, 0, 0, lat);
    chk("nonpath_data", 32'(bus.rsp_data), 32'd0);
    query(1, 10, 230, lat);
    chk("col0_row7_data", 32'(bus.rsp_data), 32'd1);

    query(2, 640, 0, lat);
    chk("oob_x_flag", 32'(bus.rsp_oob), 32'd1);
    chk("oob_x_data", 32'(bus.rsp_data), 32'd0);
    query(2, 0, 480, lat);
    chk("oob_y_flag", 32'(bus.rsp_oob), 32'd1);
    chk("oob_y_data", 32'(bus.rsp_data), 32'd0);
    query(2, 639, 479, lat);
    chk("edge_in_range_oob", 32'(bus.rsp_oob), 32'd0);

    // All requesters held high: grants must rotate, one response every third cycle.
    tick();
    for (int k = 0; k < N; k++) begin
      qx[k] = CW'(32 * (k + 3));
      qy[k] = CW'(32 * k);
    end
    req_r = '1;
    n = 0;
    for (int t = 0; t < 40 && n < 9; t++) begin
      tick();
      if (|bus.rsp_valid) begin
        chk("rr_onehot", 32'($countones(bus.rsp_valid)), 32'd1);
        owner = 0;
        for (int k = 0; k < N; k++) if (bus.rsp_valid[k]) owner = k;
        ord[n] = owner;
        at[n]  = cyc;
        n++;
      end
    end
    req_r = '0;
    chk("rr_count", 32'(n), 32'd9);
    for (int i = 1; i < 9; i++) begin
      if (i < n) begin
        chk("rr_order", 32'(ord[i]), 32'((ord[i-1] + 1) % N));
        chk("rr_gap", 32'(at[i] - at[i-1]), 32'd3);
      end
    end

    // Coordinates and req change after the sampling edge must not matter.
    tick();
    qx[0] = 10'd256;
    qy[0] = 10'd0;
    req_r[0] = 1'b1;
    wait_grant(0);
    qx[0] = 10'd700;
    qy[0] = 10'd500;
    req_r[0] = 1'b0;
    wait_rsp(0, lat);
    chk("midflight_data", 32'(bus.rsp_data), 32'd1);
    chk("midflight_oob", 32'(bus.rsp_oob), 32'd0);

    // Asynchronous reset in LOOKUP aborts the query and restarts rotation at 0.
    tick();
    qx[2] = 10'd300;
    qy[2] = 10'd40;
    req_r[2] = 1'b1;
    wait_grant(2);
    #2 Reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    req_r = '0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    qx[1] = 10'd100;
    qy[1] = 10'd100;
    qx[2] = 10'd200;
    qy[2] = 10'd200;
    req_r = 3'b110;
    n = 0;
    for (int t = 0; t < 12 && !(|bus.grant); t++) tick();
    chk("post_rst_first_grant", 32'(bus.grant), 32'b010);
    wait_rsp(1, lat);
    req_r[1] = 1'b0;
    wait_rsp(2, lat);
    req_r = '0;

    // Random traffic, including mid-flight coordinate changes and req drops.
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (bus.rsp_valid[k]) begin
          if ($urandom_range(2) == 0) begin
            qx[k] = rnd_coord(640);
            qy[k] = rnd_coord(480);
          end else begin
            req_r[k] = 1'b0;
          end
        end else if (bus.grant[k]) begin
          if ($urandom_range(4) == 0) begin
            qx[k] = rnd_coord(640);
            qy[k] = rnd_coord(480);
            req_r[k] = $urandom_range(1) == 1;
          end
        end else if (!req_r[k] && $urandom_range(2) == 0) begin
          qx[k] = rnd_coord(640);
          qy[k] = rnd_coord(480);
          req_r[k] = 1'b1;
        end
      end
    end
    req_r = '0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
